// File: rtl/mem_port_arbiter.sv
// Two-requester main-memory port arbiter (instruction fetch vs. data access) with fixed-latency tracking.
// Optional build macro MEM_ARB_RR_EN selects round-robin tie-breaking instead of fixed data priority.
module mem_port_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_data_i,
  output logic              m_data_en,
  output logic              m_write_en,
  input  logic [DATA_W-1:0] m_data_o,
  output logic              busy,
  output logic              owner
);

  localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                owner_q, owner_d;
  logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                grant;

`ifdef MEM_ARB_RR_EN
  logic                rr_q, rr_d;

  // Pointer names the last served requester; on a tie the other one wins.
  always_comb begin
    grant = d_req;
    if (i_req && d_req) begin
      grant = ~rr_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`else
  always_comb begin
    grant = d_req;
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      owner_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      owner_q   <= owner_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    owner_d   = owner_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
`ifdef MEM_ARB_RR_EN
    rr_d      = rr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req || d_req) begin
          owner_d = grant;
`ifdef MEM_ARB_RR_EN
          rr_d    = grant;
`endif
          if (grant) begin
            addr_d  = d_addr;
            wdata_d = d_wdata;
            we_d    = d_we;
          end else begin
            addr_d  = i_addr;
            we_d    = 1'b0;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          // A completed write reports zero read data to the data side.
          if (owner_q) begin
            d_rdata_d = we_q ? '0 : m_data_o;
          end else begin
            i_rdata_d = m_data_o;
          end
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Memory strobes and completion pulses come from registered state only.
  assign m_data_en  = (state_q == S_ISSUE);
  assign m_write_en = (state_q == S_ISSUE) && we_q;
  assign m_addr     = addr_q;
  assign m_data_i   = wdata_q;
  assign i_valid    = (state_q == S_RESP) && !owner_q;
  assign d_valid    = (state_q == S_RESP) && owner_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign busy       = (state_q != S_IDLE);
  assign owner      = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at MEM_LATENCY=1 (a_*) and one at MEM_LATENCY=4 (b_*),
// each backed by a small behavioural memory whose read data appears only in the cycle it is due.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic        a_reset, a_i_req, a_i_valid, a_d_req, a_d_we, a_d_valid;
  logic        a_m_data_en, a_m_write_en, a_busy, a_owner;
  logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata, a_m_addr, a_m_data_i, a_m_data_o;
  logic        b_reset, b_i_req, b_i_valid, b_d_req, b_d_we, b_d_valid;
  logic        b_m_data_en, b_m_write_en, b_busy, b_owner;
  logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata, b_m_addr, b_m_data_i, b_m_data_o;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_a (
    .clk(clk), .reset(a_reset),
    .i_req(a_i_req), .i_addr(a_i_addr), .i_rdata(a_i_rdata), .i_valid(a_i_valid),
    .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
    .d_rdata(a_d_rdata), .d_valid(a_d_valid),
    .m_addr(a_m_addr), .m_data_i(a_m_data_i), .m_data_en(a_m_data_en),
    .m_write_en(a_m_write_en), .m_data_o(a_m_data_o), .busy(a_busy), .owner(a_owner)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) u_b (
    .clk(clk), .reset(b_reset),
    .i_req(b_i_req), .i_addr(b_i_addr), .i_rdata(b_i_rdata), .i_valid(b_i_valid),
    .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
    .d_rdata(b_d_rdata), .d_valid(b_d_valid),
    .m_addr(b_m_addr), .m_data_i(b_m_data_i), .m_data_en(b_m_data_en),
    .m_write_en(b_m_write_en), .m_data_o(b_m_data_o), .busy(b_busy), .owner(b_owner)
  );

  // Behavioural memories, word-indexed by address bits [9:2]; read data is zero except when due.
  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] a_pipe;
  logic [31:0] b_pipe [4];
  logic        a_pre_we, b_pre_we;
  logic [7:0]  a_pre_idx, b_pre_idx;
  logic [31:0] a_pre_val, b_pre_val;

  always @(posedge clk) begin
    if (a_pre_we) mem_a[a_pre_idx] <= a_pre_val;
    else if (a_m_data_en && a_m_write_en) mem_a[a_m_addr[9:2]] <= a_m_data_i;
    a_pipe <= (a_m_data_en && !a_m_write_en) ? mem_a[a_m_addr[9:2]] : 32'h0;
  end
  assign a_m_data_o = a_pipe;

  always @(posedge clk) begin
    if (b_pre_we) mem_b[b_pre_idx] <= b_pre_val;
    else if (b_m_data_en && b_m_write_en) mem_b[b_m_addr[9:2]] <= b_m_data_i;
    b_pipe[0] <= (b_m_data_en && !b_m_write_en) ? mem_b[b_m_addr[9:2]] : 32'h0;
    for (int k = 1; k < 4; k++) b_pipe[k] <= b_pipe[k-1];
  end
  assign b_m_data_o = b_pipe[3];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic is_b, input logic [7:0] idx, input logic [31:0] val);
    if (is_b) begin b_pre_we = 1'b1; b_pre_idx = idx; b_pre_val = val; end
    else begin a_pre_we = 1'b1; a_pre_idx = idx; a_pre_val = val; end
    tick;
    a_pre_we = 1'b0;
    b_pre_we = 1'b0;
  endtask

  task automatic test_reset;
    a_reset = 1'b1;
    b_reset = 1'b1;
    #1;
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", a_busy); end
    n_tests++; if ({a_i_valid, a_d_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {a_i_valid, a_d_valid}); end
    n_tests++; if ({a_m_data_en, a_m_write_en} !== 2'b00) begin n_fail++; $display("FAIL reset_mem_en: got %b want 00", {a_m_data_en, a_m_write_en}); end
    n_tests++; if (a_owner !== 1'b0) begin n_fail++; $display("FAIL reset_owner: got %b want 0", a_owner); end
    n_tests++; if (a_m_addr !== 32'h0) begin n_fail++; $display("FAIL reset_m_addr: got %h want 0", a_m_addr); end
    n_tests++; if ({a_i_rdata, a_d_rdata} !== 64'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", {a_i_rdata, a_d_rdata}); end
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy_b: got %b want 0", b_busy); end
    tick;
    a_reset = 1'b0;
    b_reset = 1'b0;
    tick;
  endtask

  task automatic test_instr_read;
    a_i_addr = 32'h100;
    a_i_req  = 1'b1;
    n_tests++; if (a_busy !== 1'b0) begin n_fail++; $display("FAIL ird_busy_c0: got %b want 0", a_busy); end
    tick; // cycle 1
    n_tests++; if ({a_m_data_en, a_m_write_en} !== 2'b10) begin n_fail++; $display("FAIL ird_en_c1: got %b want 10", {a_m_data_en, a_m_write_en}); end
    n_tests++; if (a_m_addr !== 32'h100) begin n_fail++; $display("FAIL ird_addr_c1: got %h want 100", a_m_addr); end
    n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL ird_busy_c1: got %b want 1", a_busy); end
    tick; // cycle 2
    n_tests++; if ({a_m_data_en, a_i_valid, a_busy} !== 3'b001) begin n_fail++; $display("FAIL ird_c2: en/valid/busy got %b want 001", {a_m_data_en, a_i_valid, a_busy}); end
    n_tests++; if (a_m_addr !== 32'h100) begin n_fail++; $display("FAIL ird_addr_c2: got %h want 100", a_m_addr); end
    tick; // cycle 3
    n_tests++; if ({a_i_valid, a_d_valid, a_busy} !== 3'b101) begin n_fail++; $display("FAIL ird_c3: ivalid/dvalid/busy got %b want 101", {a_i_valid, a_d_valid, a_busy}); end
    n_tests++; if (a_i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ird_rdata: got %h want deadbeef", a_i_rdata); end
    a_i_req = 1'b0;
    tick; // cycle 4
    n_tests++; if ({a_i_valid, a_busy} !== 2'b00) begin n_fail++; $display("FAIL ird_c4: ivalid/busy got %b want 00", {a_i_valid, a_busy}); end
    n_tests++; if (a_i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL ird_hold: got %h want deadbeef", a_i_rdata); end
  endtask

  task automatic test_priority;
    int dv_cyc = -1, iv_cyc = -1, dv_cnt = 0, iv_cnt = 0;
    logic dv_owner = 1'b0, iv_owner = 1'b1;
    a_i_addr = 32'h100; a_d_addr = 32'h200; a_d_we = 1'b0;
    a_i_req = 1'b1; a_d_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick;
      if (a_d_valid) begin dv_cnt++; if (dv_cyc < 0) begin dv_cyc = c; dv_owner = a_owner; a_d_req = 1'b0; end end
      if (a_i_valid) begin iv_cnt++; if (iv_cyc < 0) begin iv_cyc = c; iv_owner = a_owner; a_i_req = 1'b0; end end
    end
    a_i_req = 1'b0; a_d_req = 1'b0;
    n_tests++; if (dv_cyc != 3) begin n_fail++; $display("FAIL prio_d_cycle: got %0d want 3", dv_cyc); end
    n_tests++; if (iv_cyc != 7) begin n_fail++; $display("FAIL prio_i_cycle: got %0d want 7", iv_cyc); end
    n_tests++; if ({dv_owner, iv_owner} !== 2'b10) begin n_fail++; $display("FAIL prio_owner: got %b want 10", {dv_owner, iv_owner}); end
    n_tests++; if (dv_cnt != 1 || iv_cnt != 1) begin n_fail++; $display("FAIL prio_pulses: got d=%0d i=%0d want 1 1", dv_cnt, iv_cnt); end
    n_tests++; if (a_d_rdata !== 32'hCAFEF00D) begin n_fail++; $display("FAIL prio_d_rdata: got %h want cafef00d", a_d_rdata); end
    n_tests++; if (a_i_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL prio_i_rdata: got %h want deadbeef", a_i_rdata); end
  endtask

  task automatic test_data_write;
    int we_cnt = 0;
    logic [31:0] we_addr = 32'h0, we_data = 32'h0;
    a_d_addr = 32'h600d600c; a_d_wdata = 32'h1; a_d_we = 1'b1; a_d_req = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick;
      if (a_m_write_en) begin we_cnt++; we_addr = a_m_addr; we_data = a_m_data_i; end
      if (c == 3) begin
        n_tests++; if ({a_d_valid, a_i_valid, a_owner} !== 3'b101) begin n_fail++; $display("FAIL wr_c3: dvalid/ivalid/owner got %b want 101", {a_d_valid, a_i_valid, a_owner}); end
        n_tests++; if (a_d_rdata !== 32'h0) begin n_fail++; $display("FAIL wr_rdata_zero: got %h want 0", a_d_rdata); end
        a_d_we = 1'b0;
      end
      if (c == 7) begin
        n_tests++; if (a_d_valid !== 1'b1) begin n_fail++; $display("FAIL wr_readback_valid: got %b want 1", a_d_valid); end
        n_tests++; if (a_d_rdata !== 32'h1) begin n_fail++; $display("FAIL wr_readback_data: got %h want 1", a_d_rdata); end
        a_d_req = 1'b0;
      end
    end
    n_tests++; if (we_cnt != 1) begin n_fail++; $display("FAIL wr_we_cycles: got %0d want 1", we_cnt); end
    n_tests++; if (we_addr !== 32'h600d600c || we_data !== 32'h1) begin n_fail++; $display("FAIL wr_bus: got addr %h data %h want 600d600c 1", we_addr, we_data); end
    tick;
  endtask

  task automatic test_reset_in_issue;
    int dv_cnt = 0;
    a_d_addr = 32'h40; a_d_wdata = 32'hAA; a_d_we = 1'b1; a_d_req = 1'b1;
    tick; // cycle 1: ISSUE
    n_tests++; if (a_m_write_en !== 1'b1) begin n_fail++; $display("FAIL rst_issue_we_before: got %b want 1", a_m_write_en); end
    a_reset = 1'b1;
    #1;
    n_tests++; if ({a_m_write_en, a_m_data_en, a_busy} !== 3'b000) begin n_fail++; $display("FAIL rst_issue_drop: we/en/busy got %b want 000", {a_m_write_en, a_m_data_en, a_busy}); end
    a_d_req = 1'b0;
    tick;
    a_reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick;
      if (a_d_valid) dv_cnt++;
    end
    n_tests++; if (dv_cnt != 0) begin n_fail++; $display("FAIL rst_issue_no_valid: got %0d pulses want 0", dv_cnt); end
    a_d_we = 1'b0; a_d_req = 1'b1;
    tick; tick; tick;
    n_tests++; if (a_d_valid !== 1'b1) begin n_fail++; $display("FAIL rst_issue_next_valid: got %b want 1", a_d_valid); end
    n_tests++; if (a_d_rdata !== 32'h5555) begin n_fail++; $display("FAIL rst_issue_mem_intact: got %h want 5555", a_d_rdata); end
    a_d_req = 1'b0;
    tick;
  endtask

  task automatic test_back_to_back;
    int k = 0;
    logic [3:0] owners = 4'h0;
    int vcyc [4];
    logic [3:0] exp_owners;
`ifdef MEM_ARB_RR_EN
    exp_owners = 4'b0101; // bit j = owner of grant j: D, I, D, I
`else
    exp_owners = 4'b1111;
`endif
    a_reset = 1'b1; tick; a_reset = 1'b0;
    a_i_addr = 32'h100; a_d_addr = 32'h200; a_d_we = 1'b0;
    a_i_req = 1'b1; a_d_req = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick;
      if ((a_i_valid || a_d_valid) && k < 4) begin
        owners[k] = a_owner;
        vcyc[k] = c;
        k++;
        if (k == 4) begin a_i_req = 1'b0; a_d_req = 1'b0; end
      end
    end
    a_i_req = 1'b0; a_d_req = 1'b0;
    n_tests++; if (k != 4) begin n_fail++; $display("FAIL b2b_count: got %0d grants want 4", k); end
    n_tests++; if (owners !== exp_owners) begin n_fail++; $display("FAIL b2b_owners: got %b want %b", owners, exp_owners); end
    n_tests++; if (k == 4 && (vcyc[0] != 3 || vcyc[3] != 15)) begin n_fail++; $display("FAIL b2b_timing: got first %0d last %0d want 3 15", vcyc[0], vcyc[3]); end
  endtask

  task automatic test_latency4;
    int en_cyc = -1, iv_cyc = -1, wait_cnt = 0;
    logic [31:0] md5 = 32'h0, rd = 32'h0;
    b_i_addr = 32'h200; b_i_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (b_m_data_en && en_cyc < 0) en_cyc = c;
      if (b_busy && !b_m_data_en && !b_i_valid) wait_cnt++;
      if (c == 5) md5 = b_m_data_o;
      if (b_i_valid && iv_cyc < 0) begin iv_cyc = c; rd = b_i_rdata; b_i_req = 1'b0; end
    end
    b_i_req = 1'b0;
    n_tests++; if (en_cyc != 1) begin n_fail++; $display("FAIL lat4_en_cycle: got %0d want 1", en_cyc); end
    n_tests++; if (wait_cnt != 4) begin n_fail++; $display("FAIL lat4_wait_cycles: got %0d want 4", wait_cnt); end
    n_tests++; if (iv_cyc != 6) begin n_fail++; $display("FAIL lat4_valid_cycle: got %0d want 6", iv_cyc); end
    n_tests++; if (md5 !== 32'h12345678) begin n_fail++; $display("FAIL lat4_mem_c5: got %h want 12345678", md5); end
    n_tests++; if (rd !== 32'h12345678) begin n_fail++; $display("FAIL lat4_rdata: got %h want 12345678", rd); end
    n_tests++; if (b_busy !== 1'b0) begin n_fail++; $display("FAIL lat4_idle: got busy %b want 0", b_busy); end
  endtask

  initial begin
    a_reset = 1'b1; b_reset = 1'b1;
    a_i_req = 1'b0; a_i_addr = '0; a_d_req = 1'b0; a_d_we = 1'b0; a_d_addr = '0; a_d_wdata = '0;
    b_i_req = 1'b0; b_i_addr = '0; b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = '0; b_d_wdata = '0;
    a_pre_we = 1'b0; a_pre_idx = '0; a_pre_val = '0;
    b_pre_we = 1'b0; b_pre_idx = '0; b_pre_val = '0;
    preload(1'b0, 8'd64,  32'hDEADBEEF);
    preload(1'b0, 8'd128, 32'hCAFEF00D);
    preload(1'b0, 8'd16,  32'h00005555);
    preload(1'b1, 8'd128, 32'h12345678);
    test_reset;
    test_instr_read;
    test_priority;
    test_data_write;
    test_reset_in_issue;
    test_back_to_back;
    test_latency4;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one main-memory port between two requesters: the core instruction fetch (read-only) and the core data access (read/write).
- Sits between core and main memory, in the slot reserved for caches.
- Serialises accesses with a four-state FSM and tracks the fixed memory read latency with a counter.
- Returns read data or a write acknowledge to the winning requester as a one-cycle valid pulse.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MEM_LATENCY, 1, cycles from the memory enable cycle to read data on m_data_o (≥1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- i_req  in  1  instruction read request; held until i_valid.
- i_addr  in  ADDR_W  instruction address; stable while i_req.
- i_rdata  out  DATA_W  instruction read data.
- i_valid  out  1  one-cycle completion pulse.
- d_req  in  1  data request; held until d_valid.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_rdata  out  DATA_W  data read data (0 on write).
- d_valid  out  1  one-cycle completion/ack pulse.
- m_addr  out  ADDR_W  memory address.
- m_data_i  out  DATA_W  memory write data.
- m_data_en  out  1  memory access enable.
- m_write_en  out  1  memory write enable.
- m_data_o  in  DATA_W  memory read data.
- busy  out  1  FSM not in IDLE.
- owner  out  1  current/last grant: 0 = instruction, 1 = data.

Behaviour:
- Reset (asynchronous, immediate): FSM = IDLE, counter = 0, all outputs = 0, owner = 0, round-robin pointer = 0.
- Reset during ISSUE: m_write_en drops immediately and the transaction is abandoned. No valid pulse is ever produced for it.
- State IDLE:
  - If any req is high, choose a winner (see arbitration).
  - Latch addr, wdata and we into internal registers; a latched instruction access has we = 0.
  - Set owner; next state ISSUE.
  - If no req, stay in IDLE.
- State ISSUE (exactly 1 cycle):
  - m_data_en = 1; m_write_en = latched we; m_addr and m_data_i = latched values.
  - Load counter = MEM_LATENCY-1; next state WAIT.
- State WAIT (exactly MEM_LATENCY cycles):
  - m_data_en = 0; m_addr held.
  - Counter decrements each cycle.
  - In the cycle where counter == 0: register m_data_o into the owner's rdata (a write registers 0); next state RESP.
- State RESP (1 cycle):
  - Owner's valid = 1; the other valid = 0.
  - Requests are ignored; the requester may still show req high this cycle.
  - Next state IDLE.
- Timing:
  - Request seen in IDLE at cycle t → valid at t+MEM_LATENCY+2.
  - Back-to-back throughput: one access per MEM_LATENCY+3 cycles.
- rdata registers hold their value until the next completion for the same requester.
- m_addr and m_data_i hold their last latched values outside ISSUE and WAIT.
- m_data_en and m_write_en are decoded from the state register only, so there is no glitch from the request inputs.
- Arbitration (default): fixed priority, data over instruction.
- Simultaneous i_req and d_req in IDLE: data wins; instruction waits and is served in the next IDLE.
- A req that drops before grant is simply not served. A req that drops after grant is still completed.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer holds the last served requester.
  - On a tie in IDLE, the requester other than the pointer wins.
  - The pointer updates on every grant.
  - The first tie after reset is granted to data, since the pointer resets to 0 = instruction.
- Undefined: fixed data priority as above; the pointer logic is absent.

Test Plan:
- Instruction read, MEM_LATENCY=1, memory[0x100]=0xDEADBEEF; i_req at cycle 0 with i_addr=0x100 → m_data_en=1 at cycle 1, i_valid=1 and i_rdata=0xDEADBEEF at cycle 3; busy high during cycles 1-3.
- Data write d_addr=0x600d600c, d_wdata=0x1 → m_write_en=1 with that address for exactly one cycle; d_valid at cycle 3; d_rdata=0; memory then reads back 0x1.
- i_req and d_req both held from cycle 0 → data served first (d_valid cycle 3), instruction second (i_valid cycle 7).
  - With MEM_ARB_RR_EN and both held continuously → grants alternate D, I, D, I.
- MEM_LATENCY=4: instruction read → exactly 4 WAIT cycles; i_valid at cycle 6; rdata equals m_data_o sampled at cycle 5.
- Assert reset during the ISSUE cycle of a write → m_write_en low in the same cycle; busy=0; no d_valid afterwards; a subsequent d_req completes normally.
